// File: rtl/alu_flag_reg_stack_if.sv
// Bus between the ALU result path and the flag unit: flag candidates and
// update/save/restore controls in, architectural flags and stack status out.
interface alu_flag_reg_stack_if #(
  parameter int FLAG_W = 4,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [SEL_W-1:0]         opcode;
  logic [NUM_IN*FLAG_W-1:0] in_flags;
  logic                     upd_valid;
  logic [FLAG_W-1:0]        upd_mask;
  logic                     push;
  logic                     pop;
  logic                     err_clr;
  logic [FLAG_W-1:0]        flags;
  logic [DW-1:0]            depth;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     bad_op;
  logic                     err_ovf;
  logic                     err_udf;

  modport master (
    output opcode, in_flags, upd_valid, upd_mask, push, pop, err_clr,
    input  flags, depth, stack_full, stack_empty, bad_op, err_ovf, err_udf
  );

  modport slave (
    input  opcode, in_flags, upd_valid, upd_mask, push, pop, err_clr,
    output flags, depth, stack_full, stack_empty, bad_op, err_ovf, err_udf
  );
endinterface

// File: rtl/alu_flag_reg_stack.sv
// Registered ALU flag unit: per-opcode candidate select, masked merge into the
// flag register, and a LIFO that saves/restores flags across interrupts.
module alu_flag_reg_stack #(
  parameter int                FLAG_W      = 4,
  parameter int                NUM_IN      = 16,
  parameter int                SEL_W       = 4,
  parameter int                DEPTH       = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input logic              clk,
  input logic              rst_n,
  alu_flag_reg_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0]    DEPTH_L  = DW'(DEPTH);
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  logic [FLAG_W-1:0] r_flags;
  logic [DW-1:0]     r_depth;
  logic              r_bad_op;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic [FLAG_W-1:0] r_stack [DEPTH];

  logic [FLAG_W-1:0] w_cand [NUM_IN];
  logic [FLAG_W-1:0] w_sel;
  logic [FLAG_W-1:0] w_flags_next;
  logic [AW-1:0]     w_wr_ptr;
  logic [AW-1:0]     w_rd_ptr;
  logic              w_op_ok;
  logic              w_empty;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic              w_ovf;
  logic              w_udf;
  logic              w_upd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_cand
      assign w_cand[gi] = bus.in_flags[gi*FLAG_W +: FLAG_W];
    end
  endgenerate

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.opcode == SEL_W'(k)) w_sel = w_cand[k];
    end
  end

  assign w_op_ok   = {1'b0, bus.opcode} < NUM_IN_L;
  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DEPTH_L);
  // Pop wins over push; a successful pop also masks the update for this cycle.
  assign w_do_pop  = bus.pop & ~w_empty;
  assign w_udf     = bus.pop & w_empty;
  assign w_do_push = bus.push & ~bus.pop & ~w_full;
  assign w_ovf     = bus.push & ~bus.pop & w_full;
  assign w_upd     = bus.upd_valid & ~w_do_pop;
  assign w_wr_ptr  = r_depth[AW-1:0];
  assign w_rd_ptr  = AW'(r_depth - 1'b1);

  always_comb begin
    w_flags_next = r_flags;
    if (w_do_pop)
      w_flags_next = r_stack[w_rd_ptr];
    else if (w_upd && w_op_ok)
      w_flags_next = (r_flags & ~bus.upd_mask) | (w_sel & bus.upd_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= RESET_FLAGS;
      r_depth   <= '0;
      r_bad_op  <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_flags   <= w_flags_next;
      r_bad_op  <= w_upd & ~w_op_ok;
      r_err_ovf <= w_ovf | (r_err_ovf & ~bus.err_clr);
      r_err_udf <= w_udf | (r_err_udf & ~bus.err_clr);
      if (w_do_pop)
        r_depth <= r_depth - 1'b1;
      else if (w_do_push)
        r_depth <= r_depth + 1'b1;
    end
  end

  // Stack storage carries no reset so it can map onto plain RAM; it saves pre-update flags.
  always_ff @(posedge clk) begin
    if (w_do_push) r_stack[w_wr_ptr] <= r_flags;
  end

  assign bus.flags       = r_flags;
  assign bus.depth       = r_depth;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.bad_op      = r_bad_op;
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_udf     = r_err_udf;
endmodule

// File: tb/tb_alu_flag_reg_stack.sv
// Directed bench for alu_flag_reg_stack (NUM_IN=12 so opcodes 12..15 are invalid).
module tb_alu_flag_reg_stack;
  localparam int FLAG_W = 4;
  localparam int NUM_IN = 12;
  localparam int SEL_W  = 4;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_flag_reg_stack_if #(.FLAG_W(FLAG_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEPTH(DEPTH)) bus ();

  alu_flag_reg_stack #(
    .FLAG_W(FLAG_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEPTH(DEPTH), .RESET_FLAGS(4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [3:0] val);
    bus.in_flags[k*FLAG_W +: FLAG_W] = val;
  endtask

  // One clocked transaction; outputs are stable at posedge+1 on return.
  task automatic do_cyc(input logic [3:0] op, input logic upd, input logic [3:0] m,
                        input logic ps, input logic pp, input logic clr);
    bus.opcode    = op;
    bus.upd_valid = upd;
    bus.upd_mask  = m;
    bus.push      = ps;
    bus.pop       = pp;
    bus.err_clr   = clr;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.err_clr   = 1'b0;
    $display("t=%0t op=%0d upd=%0b mask=%b push=%0b pop=%0b clr=%0b -> flags=%b depth=%0d bad_op=%0b ovf=%0b udf=%0b",
             $time, op, upd, m, ps, pp, clr, bus.flags, bus.depth, bus.bad_op, bus.err_ovf, bus.err_udf);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.opcode = '0; bus.in_flags = '0; bus.upd_valid = 1'b0; bus.upd_mask = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    #3;
    check_eq("rst_flags", 32'(bus.flags), 32'h0);
    check_eq("rst_depth", 32'(bus.depth), 32'h0);
    check_eq("rst_empty", 32'(bus.stack_empty), 32'h1);
    check_eq("rst_full", 32'(bus.stack_full), 32'h0);
    check_eq("rst_errs", 32'({bus.bad_op, bus.err_ovf, bus.err_udf}), 32'h0);
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: masked update and invalid opcode
    set_slot(3, 4'b1011);
    do_cyc(4'd3, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    check_eq("t2_masked", 32'(bus.flags), 32'b0010);
    check_eq("t2_no_bad", 32'(bus.bad_op), 32'h0);
    do_cyc(4'd3, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_eq("t2_idle_hold", 32'(bus.flags), 32'b0010);
    do_cyc(4'd12, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_eq("t2_bad_hold", 32'(bus.flags), 32'b0010);
    check_eq("t2_bad_pulse", 32'(bus.bad_op), 32'h1);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("t2_bad_one_cyc", 32'(bus.bad_op), 32'h0);

    // T3: push and update in the same cycle
    set_slot(1, 4'b0101);
    do_cyc(4'd1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_eq("t3_setup", 32'(bus.flags), 32'b0101);
    set_slot(2, 4'b1111);
    do_cyc(4'd2, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    check_eq("t3_push_upd_flags", 32'(bus.flags), 32'b1111);
    check_eq("t3_push_upd_depth", 32'(bus.depth), 32'd1);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t3_pop_flags", 32'(bus.flags), 32'b0101);
    check_eq("t3_pop_depth", 32'(bus.depth), 32'd0);

    // T4: fill with distinct saved values, overflow, drain, underflow
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_slot(0, 4'(8 + i));
      do_cyc(4'd0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    end
    check_eq("t4_full_depth", 32'(bus.depth), 32'd4);
    check_eq("t4_full_flag", 32'(bus.stack_full), 32'h1);
    check_eq("t4_ovf", 32'(bus.err_ovf), 32'h1);
    check_eq("t4_ovf_upd", 32'(bus.flags), 32'b1100);
    check_eq("t4_no_udf", 32'(bus.err_udf), 32'h0);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t4_pop1", 32'(bus.flags), 32'b1010);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t4_pop2", 32'(bus.flags), 32'b1001);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t4_pop3", 32'(bus.flags), 32'b1000);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t4_pop4", 32'(bus.flags), 32'b0101);
    check_eq("t4_empty", 32'(bus.stack_empty), 32'h1);
    set_slot(0, 4'b0110);
    do_cyc(4'd0, 1'b1, 4'b0011, 1'b1, 1'b1, 1'b0);
    check_eq("t4_udf", 32'(bus.err_udf), 32'h1);
    check_eq("t4_udf_upd", 32'(bus.flags), 32'b0110);
    check_eq("t4_udf_depth", 32'(bus.depth), 32'd0);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check_eq("t4_clr", 32'({bus.err_ovf, bus.err_udf}), 32'h0);

    // T5: pop priority over push and update
    set_slot(0, 4'b0011);
    do_cyc(4'd0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    set_slot(0, 4'b1111);
    do_cyc(4'd0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_eq("t5_pre", 32'(bus.flags), 32'b1111);
    do_cyc(4'd13, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
    check_eq("t5_flags", 32'(bus.flags), 32'b0011);
    check_eq("t5_depth", 32'(bus.depth), 32'd0);
    check_eq("t5_no_bad", 32'(bus.bad_op), 32'h0);
    check_eq("t5_no_err", 32'({bus.err_ovf, bus.err_udf}), 32'h0);

    // T6: err_clr loses to a simultaneous overflow
    for (int i = 0; i < DEPTH; i++) do_cyc(4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    check_eq("t6_full", 32'(bus.stack_full), 32'h1);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    check_eq("t6_ovf_wins", 32'(bus.err_ovf), 32'h1);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check_eq("t6_clr", 32'(bus.err_ovf), 32'h0);

    // T1: async reset mid-operation with depth=2 and a sticky error set
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    do_cyc(4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check_eq("t1_pre_depth", 32'(bus.depth), 32'd2);
    check_eq("t1_pre_ovf", 32'(bus.err_ovf), 32'h1);
    check_eq("t1_pre_flags", 32'(bus.flags), 32'b0011);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t1_flags", 32'(bus.flags), 32'h0);
    check_eq("t1_depth", 32'(bus.depth), 32'd0);
    check_eq("t1_errs", 32'({bus.bad_op, bus.err_ovf, bus.err_udf}), 32'h0);
    check_eq("t1_empty", 32'(bus.stack_empty), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
